// File: rtl/led_pkg.sv
// Shared types for the LED pattern path: scheduler FSM states and pattern ids.
package led_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SWITCH = 1'b1
    } sched_state_t;

    // Pattern id width for the default build of four generators.
    localparam int PAT_ID_W = 2;
    typedef logic [PAT_ID_W-1:0] pattern_id_t;

endpackage

// File: rtl/frame_tracker.sv
// Watches the led_driver request stream for frame wraps and keeps the
// per-pattern dwell count used by automatic rotation.
module frame_tracker
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 2,
    parameter int DWELL_FRAMES   = 60,
    localparam int CounterWidth  = $clog2(NUM_LEDS),
    localparam int DwellWidth    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CounterWidth-1:0] req_i,
    input  logic                    auto_en_i,
    input  logic                    accept_i,
    output logic                    boundary_o,
    output logic                    dwell_expired_o,
    output logic                    frame_done_o
);

    logic [CounterWidth-1:0] prev_req_q;
    logic [DwellWidth-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic                    frame_done_q;
    logic                    boundary;
    logic                    dwell_expired;

    // A wrap seen while the scheduler is mid-switch is dropped entirely.
    assign boundary      = accept_i && (prev_req_q == CounterWidth'(NUM_LEDS - 1))
                           && (req_i == '0);
    assign dwell_expired = (dwell_cnt_q == DwellWidth'(DWELL_FRAMES - 1));

    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        if (boundary) begin
            if (!auto_en_i || dwell_expired) begin
                dwell_cnt_d = '0;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_req_q   <= '0;
            dwell_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            prev_req_q   <= req_i;
            dwell_cnt_q  <= dwell_cnt_d;
            frame_done_q <= boundary;
        end
    end

    assign boundary_o      = boundary;
    assign dwell_expired_o = dwell_expired;
    assign frame_done_o    = frame_done_q;

endmodule

// File: rtl/pattern_scheduler.sv
// Time-shares one led_driver among NUM_PATTERNS generators, switching only on
// frame wraps. Define PATTERN_SCHED_TIMEOUT_EN to enable the starvation timeout.
module pattern_scheduler
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 2,
    parameter int COLOR_WIDTH    = 8,
    parameter int NUM_PATTERNS   = 4,
    parameter int DWELL_FRAMES   = 60,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CounterWidth  = $clog2(NUM_LEDS),
    localparam int PatWidth      = $clog2(NUM_PATTERNS)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [CounterWidth-1:0]             next_led_request,
    output logic [CounterWidth-1:0]             pat_request,
    input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_red_in,
    input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_green_in,
    input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_blue_in,
    input  logic [NUM_PATTERNS-1:0]             pat_valid_in,
    input  logic                                auto_en,
    input  logic [PatWidth-1:0]                 mode_sel,
    output logic [COLOR_WIDTH-1:0]              red_out,
    output logic [COLOR_WIDTH-1:0]              green_out,
    output logic [COLOR_WIDTH-1:0]              blue_out,
    output logic                                color_valid,
    output logic [PatWidth-1:0]                 active_pattern,
    output logic                                frame_done,
    output logic                                pattern_fault
);

    sched_state_t            state_q, state_d;
    logic [PatWidth-1:0]     active_q, active_d;
    logic [PatWidth-1:0]     target_q, target_d;
    logic [PatWidth-1:0]     target;
    logic [COLOR_WIDTH-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                    valid_q, valid_d;
    logic [COLOR_WIDTH-1:0]  live_red, live_green, live_blue;
    logic                    live_valid;
    logic                    boundary;
    logic                    dwell_expired;

    assign pat_request = next_led_request;

    frame_tracker #(
        .NUM_LEDS     (NUM_LEDS),
        .DWELL_FRAMES (DWELL_FRAMES)
    ) u_tracker (
        .clk_i           (clk_in),
        .rst_i           (rst_in),
        .req_i           (next_led_request),
        .auto_en_i       (auto_en),
        .accept_i        (state_q == RUN),
        .boundary_o      (boundary),
        .dwell_expired_o (dwell_expired),
        .frame_done_o    (frame_done)
    );

    assign live_red   = pat_red_in  [int'(active_q) * COLOR_WIDTH +: COLOR_WIDTH];
    assign live_green = pat_green_in[int'(active_q) * COLOR_WIDTH +: COLOR_WIDTH];
    assign live_blue  = pat_blue_in [int'(active_q) * COLOR_WIDTH +: COLOR_WIDTH];
    assign live_valid = pat_valid_in[active_q];

    // Out-of-range manual selections leave the current pattern in place.
    always_comb begin
        target = active_q;
        if (auto_en) begin
            if (dwell_expired) begin
                target = (active_q == PatWidth'(NUM_PATTERNS - 1)) ? '0 : active_q + 1'b1;
            end
        end else if (int'(mode_sel) < NUM_PATTERNS) begin
            target = mode_sel;
        end
    end

`ifdef PATTERN_SCHED_TIMEOUT_EN
    localparam int StallWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [StallWidth-1:0] stall_q, stall_d;
    logic                  fault_q, fault_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_q <= '0;
            fault_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            fault_q <= fault_d;
        end
    end

    assign pattern_fault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign pattern_fault  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        valid_d  = valid_q;
`ifdef PATTERN_SCHED_TIMEOUT_EN
        stall_d  = stall_q;
        fault_d  = fault_q;
`endif
        unique case (state_q)
            RUN: begin
                red_d   = live_red;
                green_d = live_green;
                blue_d  = live_blue;
                valid_d = live_valid;
`ifdef PATTERN_SCHED_TIMEOUT_EN
                if (live_valid) begin
                    stall_d = '0;
                    fault_d = 1'b0;
                end else begin
                    if (stall_q != StallWidth'(TIMEOUT_CYCLES)) begin
                        stall_d = stall_q + 1'b1;
                    end
                    // Starved: feed black so the strand keeps refreshing.
                    if (stall_d == StallWidth'(TIMEOUT_CYCLES)) begin
                        red_d   = '0;
                        green_d = '0;
                        blue_d  = '0;
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                    end
                end
`endif
                if (boundary && (target != active_q)) begin
                    state_d  = SWITCH;
                    target_d = target;
                end
            end
            SWITCH: begin
                active_d = target_q;
                valid_d  = 1'b0;
                state_d  = RUN;
`ifdef PATTERN_SCHED_TIMEOUT_EN
                stall_d  = '0;
                fault_d  = 1'b0;
`endif
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= RUN;
            active_q <= '0;
            target_q <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            valid_q  <= valid_d;
        end
    end

    assign red_out        = red_q;
    assign green_out      = green_q;
    assign blue_out       = blue_q;
    assign color_valid    = valid_q;
    assign active_pattern = active_q;

endmodule
